// File: rtl/ysyx_23060201_isram_pkg.sv
// Shared constants for the instruction-SRAM responder: memory window,
// FSM encodings and the LFSR step function used by the delay generator.
`ifndef YSYX_23060201_DEFINES
`define YSYX_23060201_DEFINES
`define MBASE      32'h8000_0000
`define MSIZE      32'h0800_0000
`define ISRAM_IDLE 2'd0
`define ISRAM_WAIT 2'd1
`define ISRAM_RESP 2'd2
`endif

package ysyx_23060201_isram_pkg;

  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned RND_W   = 4;

  // Fibonacci step, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

endpackage

// File: rtl/ysyx_23060201_isram_if.sv
// IFU fetch channel plus the memory-side read port of the responder.
interface ysyx_23060201_isram_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  pmem_en_c;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [DATA_WIDTH-1:0] pmem_rdata;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, pmem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, pmem_en_c, pmem_addr
  );

  modport mem (
    input  pmem_en_c, pmem_addr,
    output pmem_rdata
  );
endinterface

// File: rtl/ysyx_23060201_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when step is high; reusable
// wherever a deterministic pseudo-random delay is needed.
module ysyx_23060201_lfsr16
  import ysyx_23060201_isram_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/ysyx_23060201_isram.sv
// Instruction-memory responder: one outstanding fetch, fixed or LFSR-random
// wait, single memory read per good request, error flag for bad addresses.
module ysyx_23060201_isram
  import ysyx_23060201_isram_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH = 32,
  parameter int unsigned       DATA_WIDTH = 32,
  parameter int unsigned       LATENCY    = 1,
  parameter bit                RAND_EN    = 1'b0,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_23060201_isram_if.slave   bus
);

  localparam int unsigned CNT_W = (LATENCY > 16) ? $clog2(LATENCY) : RND_W;
  localparam int unsigned EXT_W = ADDR_WIDTH + 1;

  localparam logic [STATE_W-1:0] IDLE = `ISRAM_IDLE;
  localparam logic [STATE_W-1:0] WAIT = `ISRAM_WAIT;
  localparam logic [STATE_W-1:0] RESP = `ISRAM_RESP;

  logic [STATE_W-1:0]    state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [DATA_WIDTH-1:0] data, data_nxt;
  logic                  err, err_nxt;
  logic                  req_ready, rsp_valid;
  logic                  lfsr_step_c;
  logic                  pmem_en_c;
  logic                  addr_err_c;
  logic [LFSR_W-1:0]     lfsr_q;
  logic                  unused_lfsr_c;

  ysyx_23060201_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step_c),
    .q    (lfsr_q)
  );

  assign unused_lfsr_c = ^lfsr_q[LFSR_W-1:RND_W];

  // Range check carried at ADDR_WIDTH+1 bits so the upper bound cannot wrap.
  assign addr_err_c = (addr[1:0] != 2'b00)
                   || ({1'b0, addr} < EXT_W'(`MBASE))
                   || ({1'b0, addr} > (EXT_W'(`MBASE) + EXT_W'(`MSIZE) - EXT_W'(4)));

  // Next-state, counter and response capture.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_nxt    = addr;
    data_nxt    = data;
    err_nxt     = err;
    lfsr_step_c = 1'b0;
    pmem_en_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          addr_nxt    = bus.req_addr;
          cnt_nxt     = RAND_EN ? CNT_W'(lfsr_q[RND_W-1:0]) : CNT_W'(LATENCY - 1);
          lfsr_step_c = 1'b1;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          err_nxt   = addr_err_c;
          data_nxt  = addr_err_c ? '0 : bus.pmem_rdata;
          pmem_en_c = !addr_err_c && !rst;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      data      <= '0;
      err       <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr      <= addr_nxt;
      data      <= data_nxt;
      err       <= err_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = data;
  assign bus.rsp_err   = err;
  assign bus.pmem_en_c = pmem_en_c;
  assign bus.pmem_addr = addr;

endmodule
